// File: rtl/seatbelt_alarm_pkg.sv
// Shared types and constants for the seatbelt warning controller.
// State encodings are fixed because state_o exposes them for debug.
package seatbelt_pkg;

   localparam int             SEC_W   = 8;
   localparam logic [SEC_W-1:0] SEC_MAX = 8'd59;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_CHECK = 3'd1,
      ST_GRACE = 3'd2,
      ST_ALERT = 3'd3,
      ST_MUTE  = 3'd4
   } state_t;

   function automatic logic lamp_state(input state_t st);
      return (st == ST_GRACE) || (st == ST_ALERT) || (st == ST_MUTE);
   endfunction

endpackage

// File: rtl/seatbelt_alarm_if.sv
// Bundle of seconds/vehicle inputs and alarm outputs of seatbelt_alarm.
// master drives the inputs and observes the outputs; slave is the controller.
interface seatbelt_alarm_if;
   import seatbelt_pkg::*;

   logic [SEC_W-1:0] second_i;
   logic             ignition_i;
   logic             belt_i;
   logic             buzzer_o;
   logic             lamp_o;
   logic [2:0]       state_o;
   logic [7:0]       elapsed_o;

   modport master (
      output second_i, ignition_i, belt_i,
      input  buzzer_o, lamp_o, state_o, elapsed_o
   );

   modport slave (
      input  second_i, ignition_i, belt_i,
      output buzzer_o, lamp_o, state_o, elapsed_o
   );

endinterface

// File: rtl/seatbelt_alarm_sec_tick_detect.sv
// One-cycle tick on every change of the seconds count, wrap included.
// The last-value register loads every cycle, reset included, so no reset port is needed.
module sec_tick_detect
   import seatbelt_pkg::*;
(
   input  logic             clk_i,
   input  logic [SEC_W-1:0] i_second,
   output logic             o_tick
);

   logic [SEC_W-1:0] r_sec_q;

   always_ff @(posedge clk_i) begin
      r_sec_q <= i_second;
   end

   assign o_tick = (i_second != r_sec_q);

endmodule

// File: rtl/seatbelt_alarm.sv
// Seatbelt warning FSM: grace timer, pulsed buzzer window, mute; lamp while unbuckled.
// Optional belt filter selected by SEATBELT_ALARM_BELT_DEBOUNCE_EN.
module seatbelt_alarm
   import seatbelt_pkg::*;
#(
   parameter int GRACE_S    = 5,
   parameter int ALERT_S    = 30,
   parameter int DEB_CYCLES = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   seatbelt_alarm_if.slave  sb
);

   if (GRACE_S < 1 || GRACE_S > 255 || ALERT_S < 1 || ALERT_S > 255 ||
       DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_param
      $error("seatbelt_alarm: parameter out of range 1..255");
   end

   logic       w_tick;
   logic       w_belt;
   state_t     r_state;
   state_t     w_nxt;
   logic [7:0] r_elapsed;
   logic [7:0] w_elapsed_nxt;
   logic [8:0] w_elapsed_inc;
   logic       r_buzzer;
   logic       w_buzzer_nxt;
   logic       r_lamp;

   sec_tick_detect u_tick (
      .clk_i    (clk_i),
      .i_second (sb.second_i),
      .o_tick   (w_tick)
   );

`ifdef SEATBELT_ALARM_BELT_DEBOUNCE_EN
   logic       r_belt_s1;
   logic       r_belt_s2;
   logic       r_belt_f;
   logic [7:0] r_deb_cnt;
   logic       w_deb_done;

   // Release the new value in the last stable cycle so the FSM reacts 2+DEB_CYCLES after the edge.
   assign w_deb_done = (r_belt_s2 != r_belt_f) &&
                       (({1'b0, r_deb_cnt} + 9'd1) == 9'(DEB_CYCLES));
   assign w_belt     = w_deb_done ? r_belt_s2 : r_belt_f;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_belt_s1 <= 1'b0;
         r_belt_s2 <= 1'b0;
         r_belt_f  <= 1'b0;
         r_deb_cnt <= 8'd0;
      end else begin
         r_belt_s1 <= sb.belt_i;
         r_belt_s2 <= r_belt_s1;
         if (r_belt_s2 != r_belt_f) begin
            if (w_deb_done) begin
               r_belt_f  <= r_belt_s2;
               r_deb_cnt <= 8'd0;
            end else begin
               r_deb_cnt <= r_deb_cnt + 8'd1;
            end
         end else begin
            r_deb_cnt <= 8'd0;
         end
      end
   end
`else
   assign w_belt = sb.belt_i;
`endif

   assign w_elapsed_inc = {1'b0, r_elapsed} + 9'd1;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_OFF, ST_CHECK, ST_GRACE, ST_ALERT, ST_MUTE: begin
            if (!sb.ignition_i) begin
               w_nxt = ST_OFF;
            end else if (w_belt) begin
               w_nxt = ST_CHECK;
            end else begin
               case (r_state)
                  ST_OFF, ST_CHECK: w_nxt = ST_GRACE;
                  ST_GRACE: if (w_tick && w_elapsed_inc == 9'(GRACE_S)) w_nxt = ST_ALERT;
                  ST_ALERT: if (w_tick && w_elapsed_inc == 9'(ALERT_S)) w_nxt = ST_MUTE;
                  default:  w_nxt = r_state;
               endcase
            end
         end
         default: w_nxt = ST_OFF;
      endcase
   end

   always_comb begin
      w_elapsed_nxt = 8'd0;
      if (w_nxt == r_state && (r_state == ST_GRACE || r_state == ST_ALERT)) begin
         if (w_tick && r_elapsed != 8'hFF) begin
            w_elapsed_nxt = r_elapsed + 8'd1;
         end else begin
            w_elapsed_nxt = r_elapsed;
         end
      end
   end

   // Buzzer turns on in the first ALERT second and toggles on each tick after that.
   always_comb begin
      w_buzzer_nxt = 1'b0;
      if (r_state == ST_ALERT && w_nxt == ST_ALERT) begin
         if (w_tick) begin
            w_buzzer_nxt = ~r_buzzer;
         end else if (r_elapsed == 8'd0) begin
            w_buzzer_nxt = 1'b1;
         end else begin
            w_buzzer_nxt = r_buzzer;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= ST_OFF;
         r_elapsed <= 8'd0;
         r_buzzer  <= 1'b0;
         r_lamp    <= 1'b0;
      end else begin
         r_state   <= w_nxt;
         r_elapsed <= w_elapsed_nxt;
         r_buzzer  <= w_buzzer_nxt;
         r_lamp    <= lamp_state(r_state);
      end
   end

   assign sb.state_o   = r_state;
   assign sb.elapsed_o = r_elapsed;
   assign sb.buzzer_o  = r_buzzer;
   assign sb.lamp_o    = r_lamp;

endmodule

// File: tb/tb_seatbelt_alarm.sv
// Scoreboard bench for seatbelt_alarm: stimulus pushes expected outputs per cycle, a monitor pops and compares.
module tb_seatbelt_alarm;
   import seatbelt_pkg::*;

   typedef struct {
      int         cyc;
      logic [2:0] st;
      logic       lamp;
      logic       buz;
      logic [7:0] el;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   seatbelt_alarm_if sb ();

   seatbelt_alarm #(.GRACE_S(5), .ALERT_S(3), .DEB_CYCLES(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .sb    (sb)
   );

   task automatic drive(input logic r, input logic [7:0] s, input logic ig, input logic bl);
      @(negedge clk);
      rst           = r;
      sb.second_i   = s;
      sb.ignition_i = ig;
      sb.belt_i     = bl;
   endtask

   task automatic exp_push(input logic [2:0] st, input logic lp, input logic bz,
                           input logic [7:0] el, input string nm);
      exp_t e;
      e.cyc = cyc + 1; e.st = st; e.lamp = lp; e.buz = bz; e.el = el; e.name = nm;
      q.push_back(e);
   endtask

   task automatic go(input logic [7:0] s, input logic ig, input logic bl, input logic [2:0] st,
                     input logic lp, input logic bz, input logic [7:0] el, input string nm);
      drive(1'b0, s, ig, bl);
      exp_push(st, lp, bz, el, nm);
   endtask

   task automatic chk_tick(input logic e, input string nm);
      #1;
      checks++;
      if (dut.w_tick !== e) begin
         failures++;
         $display("FAIL %s: tick got %b want %b", nm, dut.w_tick, e);
      end
   endtask

   task automatic reset_seq();
      repeat (3) drive(1'b1, 8'd17, 1'b0, 1'b0);
      exp_push(ST_OFF, 1'b0, 1'b0, 8'd0, "reset_values");
      go(8'd17, 1'b0, 1'b0, ST_OFF, 1'b0, 1'b0, 8'd0, "post_reset");
      chk_tick(1'b0, "no_tick_after_reset");
      go(8'd17, 1'b0, 1'b0, ST_OFF, 1'b0, 1'b0, 8'd0, "post_reset_hold");
   endtask

   // Monitor: compares every expectation whose target cycle has arrived.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || sb.state_o !== e.st || sb.lamp_o !== e.lamp ||
                sb.buzzer_o !== e.buz || sb.elapsed_o !== e.el) begin
               failures++;
               $display("FAIL %s cyc=%0d: got st=%0d lamp=%b buz=%b el=%0d want st=%0d lamp=%b buz=%b el=%0d",
                        e.name, cyc, sb.state_o, sb.lamp_o, sb.buzzer_o, sb.elapsed_o,
                        e.st, e.lamp, e.buz, e.el);
            end
         end
      end
   end

   initial begin
      sb.second_i   = 8'd17;
      sb.ignition_i = 1'b0;
      sb.belt_i     = 1'b0;
      reset_seq();
`ifdef SEATBELT_ALARM_BELT_DEBOUNCE_EN
      go(8'd17, 1'b1, 1'b0, ST_GRACE, 1'b0, 1'b0, 8'd0, "deb_grace");
      go(8'd17, 1'b1, 1'b0, ST_GRACE, 1'b1, 1'b0, 8'd0, "deb_grace_hold");
      for (int k = 0; k < 3; k++) go(8'd17, 1'b1, 1'b1, ST_GRACE, 1'b1, 1'b0, 8'd0, "deb_glitch");
      for (int k = 0; k < 6; k++) go(8'd17, 1'b1, 1'b0, ST_GRACE, 1'b1, 1'b0, 8'd0, "deb_glitch_ignored");
      for (int k = 1; k <= 6; k++)
         go(8'd17, 1'b1, 1'b1, (k == 6) ? ST_CHECK : ST_GRACE, 1'b1, 1'b0, 8'd0, "deb_rise");
      go(8'd17, 1'b1, 1'b0, ST_CHECK, 1'b0, 1'b0, 8'd0, "deb_check_hold");
`else
      // Buckled with ignition on: CHECK, no lamp, no buzzer.
      go(8'd0, 1'b1, 1'b1, ST_CHECK, 1'b0, 1'b0, 8'd0, "buckled_entry");
      chk_tick(1'b1, "tick_on_change");
      for (int s = 1; s <= 10; s++)
         go(8'(s), 1'b1, 1'b1, ST_CHECK, 1'b0, 1'b0, 8'd0, "buckled_check");
      // Grace across the 59->0 wrap, then alert and mute.
      go(8'd55, 1'b1, 1'b0, ST_GRACE, 1'b0, 1'b0, 8'd0, "grace_entry");
      go(8'd55, 1'b1, 1'b0, ST_GRACE, 1'b1, 1'b0, 8'd0, "grace_hold");
      for (int i = 1; i <= 4; i++) begin
         go(8'(55 + i), 1'b1, 1'b0, ST_GRACE, 1'b1, 1'b0, 8'(i), "grace_tick");
         go(8'(55 + i), 1'b1, 1'b0, ST_GRACE, 1'b1, 1'b0, 8'(i), "grace_wait");
      end
      go(8'd0, 1'b1, 1'b0, ST_ALERT, 1'b1, 1'b0, 8'd0, "alert_on_wrap");
      chk_tick(1'b1, "wrap_tick");
      go(8'd0, 1'b1, 1'b0, ST_ALERT, 1'b1, 1'b1, 8'd0, "buzzer_on");
      go(8'd1, 1'b1, 1'b0, ST_ALERT, 1'b1, 1'b0, 8'd1, "buzzer_toggle_off");
      go(8'd1, 1'b1, 1'b0, ST_ALERT, 1'b1, 1'b0, 8'd1, "buzzer_hold_off");
      go(8'd2, 1'b1, 1'b0, ST_ALERT, 1'b1, 1'b1, 8'd2, "buzzer_toggle_on");
      go(8'd3, 1'b1, 1'b0, ST_MUTE, 1'b1, 1'b0, 8'd0, "mute_entry");
      go(8'd3, 1'b1, 1'b0, ST_MUTE, 1'b1, 1'b0, 8'd0, "mute_hold");
      go(8'd4, 1'b1, 1'b0, ST_MUTE, 1'b1, 1'b0, 8'd0, "mute_tick");
      go(8'd5, 1'b1, 1'b0, ST_MUTE, 1'b1, 1'b0, 8'd0, "mute_tick2");
      go(8'd5, 1'b0, 1'b0, ST_OFF, 1'b1, 1'b0, 8'd0, "ign_off");
      go(8'd5, 1'b0, 1'b0, ST_OFF, 1'b0, 1'b0, 8'd0, "off_lamp");
      // Buckle on the same cycle as the alert-triggering tick.
      go(8'd5, 1'b1, 1'b0, ST_GRACE, 1'b0, 1'b0, 8'd0, "regrace");
      go(8'd5, 1'b1, 1'b0, ST_GRACE, 1'b1, 1'b0, 8'd0, "regrace_hold");
      for (int i = 1; i <= 4; i++)
         go(8'(5 + i), 1'b1, 1'b0, ST_GRACE, 1'b1, 1'b0, 8'(i), "regrace_tick");
      go(8'd10, 1'b1, 1'b1, ST_CHECK, 1'b1, 1'b0, 8'd0, "buckle_on_tick");
      go(8'd10, 1'b1, 1'b1, ST_CHECK, 1'b0, 1'b0, 8'd0, "buckle_lamp_off");
      // Ignition drop mid-ALERT.
      go(8'd10, 1'b1, 1'b0, ST_GRACE, 1'b0, 1'b0, 8'd0, "g2_entry");
      go(8'd10, 1'b1, 1'b0, ST_GRACE, 1'b1, 1'b0, 8'd0, "g2_hold");
      for (int i = 1; i <= 4; i++)
         go(8'(10 + i), 1'b1, 1'b0, ST_GRACE, 1'b1, 1'b0, 8'(i), "g2_tick");
      go(8'd15, 1'b1, 1'b0, ST_ALERT, 1'b1, 1'b0, 8'd0, "a2_entry");
      go(8'd15, 1'b1, 1'b0, ST_ALERT, 1'b1, 1'b1, 8'd0, "a2_buzzer");
      go(8'd16, 1'b0, 1'b0, ST_OFF, 1'b1, 1'b0, 8'd0, "ign_drop_alert");
      go(8'd16, 1'b0, 1'b0, ST_OFF, 1'b0, 1'b0, 8'd0, "ign_drop_lamp");
      // Reset mid-ALERT.
      go(8'd16, 1'b1, 1'b0, ST_GRACE, 1'b0, 1'b0, 8'd0, "g3_entry");
      go(8'd16, 1'b1, 1'b0, ST_GRACE, 1'b1, 1'b0, 8'd0, "g3_hold");
      for (int i = 1; i <= 4; i++)
         go(8'(16 + i), 1'b1, 1'b0, ST_GRACE, 1'b1, 1'b0, 8'(i), "g3_tick");
      go(8'd21, 1'b1, 1'b0, ST_ALERT, 1'b1, 1'b0, 8'd0, "a3_entry");
      go(8'd21, 1'b1, 1'b0, ST_ALERT, 1'b1, 1'b1, 8'd0, "a3_buzzer");
      drive(1'b1, 8'd22, 1'b1, 1'b0);
      exp_push(ST_OFF, 1'b0, 1'b0, 8'd0, "reset_mid_alert");
      go(8'd22, 1'b1, 1'b0, ST_GRACE, 1'b0, 1'b0, 8'd0, "after_reset");
      chk_tick(1'b0, "no_tick_after_reset2");
`endif
      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations never compared, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
